// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and the MIPS datapath/memory.
// The controller takes the master side; the datapath and memory take the slave side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic       pc_we_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] aluOP;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       bus_error;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, mem_we, ir_we, pc_we, pc_we_cond, branch_ne, pc_src,
               alu_src_a, alu_src_b, aluOP, reg_we, reg_dst, wb_sel,
               illegal, bus_error, state_o
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, mem_we, ir_we, pc_we, pc_we_cond, branch_ne, pc_src,
               alu_src_a, alu_src_b, aluOP, reg_we, reg_dst, wb_sel,
               illegal, bus_error, state_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences the shared ALU, memory
// port and register file, with a timeout on the memory handshake.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | latch opcode/funct, precompute branch target
// EXEC_R   | ALU op on rs, rt
// EXEC_I   | ALU op on rs, immediate
// WB_R     | write ALU result to rd
// WB_I     | write ALU result (or li immediate) to rt
// MEM_ADDR | compute rs + offset
// MEM_RD   | load request, wait for mem_ready
// MEM_WR   | store request, wait for mem_ready
// WB_MEM   | write load data to rt
// BRANCH   | compare rs, rt; conditional PC write
// JUMP     | PC <= jump target (jal also links to $31)
// JR       | PC <= rs
module multicycle_control #(
    parameter int TO_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_R     = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       pc_we;
        logic       pc_we_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LI    = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          r_state;
    logic [5:0]      r_op;
    logic [5:0]      r_funct;
    logic [TO_W-1:0] r_to_cnt;
    ctl_t            r_ctl;

    state_t     w_next;
    logic [5:0] w_op_next;
    logic [5:0] w_funct_next;
    logic       w_wait;
    logic       w_timeout;
    logic       w_illegal;
    logic       w_ir_we;

    // Moore decode of the datapath controls for a state and its latched opcode.
    function automatic ctl_t decode_ctl(input state_t s, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = 3'b010;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b10;
                c.alu_op    = 3'b010;
            end
            S_EXEC_R: c.alu_src_a = 1'b1;
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                case (op)
                    OP_ORI:  begin c.alu_src_b = 2'b11; c.alu_op = 3'b001; end
                    OP_ANDI: begin c.alu_src_b = 2'b11; c.alu_op = 3'b110; end
                    OP_SLTI: begin c.alu_src_b = 2'b10; c.alu_op = 3'b111; end
                    OP_LI:   begin c.alu_src_b = 2'b10; c.alu_op = 3'b011; end
                    default: begin c.alu_src_b = 2'b10; c.alu_op = 3'b010; end
                endcase
            end
            S_WB_R: begin
                c.reg_we  = 1'b1;
                c.reg_dst = 2'b01;
            end
            S_WB_I: begin
                c.reg_we = 1'b1;
                c.wb_sel = (op == OP_LI) ? 2'b11 : 2'b00;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 3'b010;
            end
            S_MEM_RD: c.mem_req = 1'b1;
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
            end
            S_WB_MEM: begin
                c.reg_we = 1'b1;
                c.wb_sel = 2'b01;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = 3'b100;
                c.pc_we_cond = 1'b1;
                c.pc_src     = 2'b01;
                c.branch_ne  = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_we  = 1'b1;
                c.pc_src = 2'b10;
                c.alu_op = 3'b101;
                if (op == OP_JAL) begin
                    c.reg_we  = 1'b1;
                    c.reg_dst = 2'b10;
                    c.wb_sel  = 2'b10;
                end
            end
            S_JR: begin
                c.pc_we  = 1'b1;
                c.pc_src = 2'b11;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // A wait state only counts once its request is actually on the bus; this keeps
    // the post-reset FETCH cycle (outputs still zero) from consuming mem_ready.
    assign w_wait    = r_ctl.mem_req;
    assign w_timeout = w_wait && !bus.mem_ready && (r_to_cnt == TO_LIMIT);
    assign w_ir_we   = (r_state == S_FETCH) && w_wait && bus.mem_ready;

    always_comb begin
        w_next       = r_state;
        w_op_next    = r_op;
        w_funct_next = r_funct;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_wait && bus.mem_ready) w_next = S_DECODE;
                else if (w_timeout)          w_next = S_FETCH;
            end
            S_DECODE: begin
                w_op_next    = bus.opcode;
                w_funct_next = bus.funct;
                case (w_op_next)
                    OP_RTYPE:       w_next = (w_funct_next == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J, OP_JAL:   w_next = S_JUMP;
                    OP_ORI, OP_ADDI, OP_LI, OP_ANDI, OP_SLTI: w_next = S_EXEC_I;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R:   w_next = S_WB_R;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready)  w_next = S_WB_MEM;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_MEM_WR: begin
                if (bus.mem_ready || w_timeout) w_next = S_FETCH;
            end
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_FETCH;
            r_op     <= '0;
            r_funct  <= '0;
            r_to_cnt <= '0;
            r_ctl    <= '0;
        end else begin
            r_state <= w_next;
            r_op    <= w_op_next;
            r_funct <= w_funct_next;
            r_ctl   <= decode_ctl(w_next, w_op_next);
            if (w_wait && !bus.mem_ready && !w_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
            else                                        r_to_cnt <= '0;
        end
    end

    assign bus.mem_req    = r_ctl.mem_req;
    assign bus.mem_we     = r_ctl.mem_we;
    assign bus.ir_we      = w_ir_we;
    assign bus.pc_we      = r_ctl.pc_we | w_ir_we;
    assign bus.pc_we_cond = r_ctl.pc_we_cond;
    assign bus.branch_ne  = r_ctl.branch_ne;
    assign bus.pc_src     = r_ctl.pc_src;
    assign bus.alu_src_a  = r_ctl.alu_src_a;
    assign bus.alu_src_b  = r_ctl.alu_src_b;
    assign bus.aluOP      = r_ctl.alu_op;
    assign bus.reg_we     = r_ctl.reg_we;
    assign bus.reg_dst    = r_ctl.reg_dst;
    assign bus.wb_sel     = r_ctl.wb_sel;
    assign bus.illegal    = w_illegal;
    assign bus.bus_error  = w_timeout;
    assign bus.state_o    = r_state;

endmodule
